// File: rtl/project_pkg.sv
// Shared types and constants for the project activator: FSM states, the
// "no project" id and the id-width legality rule.
package project_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam int ID_NONE          = 0;
    localparam int NUM_PROJECTS_DEF = 3;
    localparam int SEL_W_DEF        = 4;

    // The id field must be able to name every project plus "none".
    function automatic bit sel_w_ok(input int sel_w, input int num_projects);
        return (2 ** sel_w) > num_projects;
    endfunction

endpackage

// File: rtl/guard_timer.sv
// Load/decrement down-counter; done is high while the count sits at zero.
module guard_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/project_activator.sv
// Owns the shared io pads: grants at most one project its active enable,
// with an all-isolated guard interval on every switchover and optional auto-scan.
module project_activator
    import project_pkg::*;
#(
    parameter int NUM_PROJECTS = NUM_PROJECTS_DEF,
    parameter int SEL_W        = SEL_W_DEF,
    parameter int GUARD_CYCLES = 4,
    parameter int DWELL_W      = 16
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    sel_valid,
    output logic                    sel_ready,
    input  logic [SEL_W-1:0]        sel_id,
    input  logic                    auto_en,
    input  logic [DWELL_W-1:0]      dwell,
    output logic [NUM_PROJECTS-1:0] active,
    output logic                    isolate,
    output logic [SEL_W-1:0]        cur_id,
    output logic                    err_invalid
);

    localparam int GW = (GUARD_CYCLES > 2) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [SEL_W-1:0] MAX_ID     = SEL_W'(NUM_PROJECTS);
    localparam logic [SEL_W-1:0] NONE_ID    = SEL_W'(ID_NONE);
    localparam logic [GW-1:0]    GUARD_LOAD = GW'(GUARD_CYCLES - 1);

    state_t               state;
    logic [SEL_W-1:0]     target;
    logic [DWELL_W-1:0]   dwell_cnt;
    logic [DWELL_W-1:0]   dwell_q;

    logic                 timer_done;
    logic                 ext_acc;
    logic                 dwell_live;
    logic                 dwell_hit;
    logic                 req_valid;
    logic                 req_bad;
    logic                 start_guard;
    logic [SEL_W-1:0]     next_id;
    logic [SEL_W-1:0]     req_id;
    logic [DWELL_W-1:0]   dwell_next;

    // An external request always beats the auto-scan request raised in the same cycle;
    // a freshly written dwell value counts as "mid-count" and restarts the dwell counter.
    always_comb begin
        ext_acc     = sel_valid && sel_ready && (state != ST_GUARD);
        dwell_live  = (state == ST_RUN) && auto_en && (dwell != '0) && (dwell == dwell_q);
        dwell_hit   = dwell_live && (dwell_cnt == dwell - DWELL_W'(1));
        dwell_next  = (dwell_live && !dwell_hit) ? dwell_cnt + DWELL_W'(1) : '0;
        next_id     = (cur_id == MAX_ID) ? SEL_W'(1) : cur_id + SEL_W'(1);
        req_valid   = ext_acc || dwell_hit;
        req_id      = ext_acc ? sel_id : next_id;
        req_bad     = req_id > MAX_ID;
        start_guard = (state != ST_GUARD) && req_valid && !req_bad && (req_id != cur_id);
    end

    guard_timer #(
        .W(GW)
    ) u_guard_timer (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .load     (start_guard),
        .load_val (GUARD_LOAD),
        .dec      (state == ST_GUARD),
        .done     (timer_done)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= ST_IDLE;
            active      <= '0;
            isolate     <= 1'b1;
            cur_id      <= NONE_ID;
            sel_ready   <= 1'b1;
            err_invalid <= 1'b0;
            target      <= NONE_ID;
            dwell_cnt   <= '0;
            dwell_q     <= '0;
        end else begin
            err_invalid <= 1'b0;
            dwell_q     <= dwell;
            case (state)
                ST_GUARD: begin
                    if (timer_done) begin
                        sel_ready <= 1'b1;
                        dwell_cnt <= '0;
                        if (target == NONE_ID) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_RUN;
                            active  <= NUM_PROJECTS'(1) << (target - SEL_W'(1));
                            isolate <= 1'b0;
                            cur_id  <= target;
                        end
                    end
                end
                default: begin
                    dwell_cnt <= dwell_next;
                    if (req_valid) begin
                        if (req_bad) begin
                            err_invalid <= 1'b1;
                        end else if (req_id == cur_id) begin
                            dwell_cnt <= '0;
                        end else begin
                            state     <= ST_GUARD;
                            target    <= req_id;
                            active    <= '0;
                            isolate   <= 1'b1;
                            cur_id    <= NONE_ID;
                            sel_ready <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/project_activator.md
Name: project_activator

Overview:
- Sequences which wrapped project owns the shared io pads and drives the per-project `active` enables.
- Guarantees the enables are one-hot or all-zero, never two at once.
- Inserts a guard interval with every output isolated on every switchover.
- Optional auto-scan mode rotates through projects on a programmable dwell time. Sits in user_project_wrapper between the logic-analyser/Wishbone control bits and the `active` inputs of the wrapped projects.

Parameters:
- NUM_PROJECTS, 3, number of wrapped projects; project ids 1..NUM_PROJECTS, id 0 = none.
- SEL_W, 4, width of the project id; must satisfy 2**SEL_W > NUM_PROJECTS.
- GUARD_CYCLES, 4, cycles all enables stay low between deselect and select; minimum 1.
- DWELL_W, 16, width of the auto-scan dwell counter.

Ports:
- wb_clk_i, input, 1: sole clock.
- wb_rst_i, input, 1: synchronous, active-high reset.
- sel_valid, input, 1: select request valid.
- sel_ready, output, 1: request accepted when sel_valid && sel_ready.
- sel_id, input, SEL_W: requested project id (0 = deselect all).
- auto_en, input, 1: enable auto-scan rotation.
- dwell, input, DWELL_W: RUN cycles per project in auto-scan; 0 disables rotation.
- active, output, NUM_PROJECTS: bit k-1 high enables project k.
- isolate, output, 1: high whenever no project is enabled; the wrapper forces io_oeb high with it.
- cur_id, output, SEL_W: id of the currently enabled project (0 if none).
- err_invalid, output, 1: one-cycle pulse on an accepted id > NUM_PROJECTS.

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset is synchronous and active-high on wb_rst_i. All outputs are registered.
- Reset values: state=IDLE, active=0, isolate=1, cur_id=0, sel_ready=1, err_invalid=0, counters=0. Asserting reset in any state (including mid-GUARD) returns to these values on the next edge.
- States: IDLE, GUARD, RUN. sel_ready = (state != GUARD).
- Accept in IDLE or RUN. A request is taken on any cycle with sel_valid && sel_ready:
  - sel_id > NUM_PROJECTS: err_invalid=1 for the next cycle; state, active and cur_id are unchanged.
  - sel_id == cur_id: no-op. In RUN this restarts the dwell counter.
  - Otherwise: latch target=sel_id and enter GUARD on the next edge. active=0, isolate=1 and cur_id=0 in the same edge, so the old enable drops 1 cycle after acceptance.
- GUARD:
  - Counter loads GUARD_CYCLES-1 and decrements; active stays 0 for exactly GUARD_CYCLES cycles.
  - At count 0: target==0 → IDLE. Otherwise → RUN, with active bit target-1 set, isolate=0 and cur_id=target on that edge.
  - sel_valid is ignored while in GUARD; the requester holds the request until sel_ready.
- RUN and auto-scan:
  - The dwell counter increments each RUN cycle when auto_en && dwell != 0.
  - When dwell_cnt == dwell-1, an internal request is raised for id next = (cur_id == NUM_PROJECTS) ? 1 : cur_id+1, and the sequence proceeds exactly as an external accept.
  - An external sel_valid in the same cycle wins, and the internal request is dropped.
  - With NUM_PROJECTS == 1, rotation is a no-op that restarts the dwell counter.
  - Clearing auto_en or writing dwell mid-count resets dwell_cnt to 0.
- Invariants:
  - active is always one-hot or zero (at most one bit set).
  - isolate == (active == 0).
  - Between any two distinct nonzero active values there are ≥ GUARD_CYCLES cycles with active==0.
- Width rule: dwell_cnt is DWELL_W bits and never wraps, because it clears at the match.

Decomposition:
- Shared package project_pkg: state enum (IDLE/GUARD/RUN), ID_NONE=0, NUM_PROJECTS default, and the SEL_W rule.
- One natural sub-module, guard_timer: a load/decrement down-counter with a `done` flag, reused for the GUARD interval. The dwell counter stays inline.

Test Plan:
- Reset then sel_id=2 request → sel_ready=1 at accept; active=000 for 4 cycles; then active=010, cur_id=2, isolate=0.
- In RUN on project 2, request id=3 → active goes 010→000 one cycle after accept, stays 000 for exactly 4 cycles, then 100.
- Request id=5 while running project 1 → err_invalid pulses 1 cycle; active stays 001.
- auto_en=1, dwell=10, starting on project 3 → after 10 RUN cycles enter GUARD, then active=001 (wrap 3→1).
- External sel_id=0 coincident with the auto dwell expiry → external wins; after GUARD, state IDLE, active=000, isolate=1.
- Assert wb_rst_i during GUARD (and separately during RUN) → next edge active=000, cur_id=0, sel_ready=1; sel_valid during GUARD is never acknowledged.
